// File: rtl/aes_pkg.sv
// Shared types, constants and GF(2^8) helpers for the iterative AES datapath.
// The S-box helpers derive each table entry from the field inverse and affine map.
package aes_pkg;

    typedef logic [7:0] byte_t;
    typedef byte_t [0:3][0:3] state_t;

    localparam int NB_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sb_state_e;

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) || (lanes == 8) || (lanes == 16);
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as the S-box requires.
    function automatic byte_t gf_inv(input byte_t a);
        byte_t sq;
        byte_t res;
        sq  = a;
        res = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic byte_t rotl8(input byte_t b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic byte_t sbox_fwd(input byte_t b);
        byte_t x;
        x = gf_inv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic byte_t sbox_inv(input byte_t b);
        byte_t y;
        y = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
        return gf_inv(y);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box: combinational 8-bit substitution used on the decrypt path.
module inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_inv(in_byte);

endmodule

// File: rtl/sbox.sv
// Forward AES S-box: combinational 8-bit substitution.
module sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = sbox_fwd(in_byte);

endmodule

// File: rtl/sub_bytes_iter.sv
// Multi-cycle SubBytes/InvSubBytes engine: LANES lookups per beat over a 4x4 state,
// with valid/ready handshakes on input and output.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the source holds its data while valid && !ready, and ready never depends on valid.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 0
)
(
    input  logic   clk,
    input  logic   rst,
    input  logic   in_valid,
    output logic   in_ready,
    input  logic   in_inv,
    input  state_t in_state,
    output logic   out_valid,
    input  logic   out_ready,
    output state_t out_state,
    output logic   busy
);

    localparam int BEATS = NB_BYTES / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LB    = $clog2(LANES);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    if (!lanes_legal(LANES)) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
    end
    if ((PIPE != 0) && (PIPE != 1)) begin : g_bad_pipe
        $error("sub_bytes_iter: PIPE must be 0 or 1");
    end

    sb_state_e      state_q;
    sb_state_e      state_d;
    logic [BW-1:0]  beat_q;
    logic           issued_q;
    logic           mode_q;
    state_t         work_q;
    state_t         work_d;

    logic           accept;
    logic           issue;
    logic           wr_en;
    logic           wr_last;
    logic           done_go;

    logic [3:0]     rd_idx   [LANES];
    byte_t          lut_byte [LANES];
    logic [3:0]     wr_idx   [LANES];
    byte_t          wr_byte  [LANES];

    assign accept  = in_valid && in_ready;
    // issued_q stops lookups once the last beat has left for the pipeline stage.
    assign issue   = (state_q == RUN) && !issued_q;
    assign done_go = wr_en && wr_last;

    // Linear byte k = beat*LANES + l lives at row k%4, column k/4.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        byte_t rd_byte;
        byte_t fwd_byte;
        byte_t inv_byte;

        assign rd_idx[l] = 4'((32'(beat_q) << LB) + l);
        assign rd_byte   = work_q[rd_idx[l][1:0]][rd_idx[l][3:2]];

        sbox u_sbox (
            .in_byte  (rd_byte),
            .out_byte (fwd_byte)
        );

        inv_sbox u_inv_sbox (
            .in_byte  (rd_byte),
            .out_byte (inv_byte)
        );

        assign lut_byte[l] = mode_q ? inv_byte : fwd_byte;
    end

    if (PIPE != 0) begin : g_pipe
        logic       v_q;
        logic       last_q;
        logic [3:0] idx_q  [LANES];
        byte_t      byte_q [LANES];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q    <= 1'b0;
                last_q <= 1'b0;
            end else begin
                v_q    <= issue;
                last_q <= issue && (beat_q == LAST_BEAT);
            end
            for (int l = 0; l < LANES; l++) begin
                idx_q[l]  <= rd_idx[l];
                byte_q[l] <= lut_byte[l];
            end
        end

        assign wr_en   = v_q;
        assign wr_last = last_q;
        assign wr_idx  = idx_q;
        assign wr_byte = byte_q;
    end else begin : g_direct
        assign wr_en   = issue;
        assign wr_last = issue && (beat_q == LAST_BEAT);
        assign wr_idx  = rd_idx;
        assign wr_byte = lut_byte;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (done_go) state_d = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        work_d = work_q;
        if (accept) begin
            work_d = in_state;
        end else if (wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                work_d[wr_idx[l][1:0]][wr_idx[l][3:2]] = wr_byte[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        work_q <= work_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            issued_q  <= 1'b0;
            mode_q    <= 1'b0;
            out_state <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                beat_q   <= '0;
                issued_q <= 1'b0;
                mode_q   <= in_inv;
            end else if (issue) begin
                if (beat_q == LAST_BEAT) issued_q <= 1'b1;
                else                     beat_q   <= beat_q + 1'b1;
            end
            // The final beat's bytes are folded in here so DONE shows the complete state.
            if (done_go) out_state <= work_d;
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter across every legal LANES/PIPE combination.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    localparam int NCFG = 10;
    localparam int MAIN = 4;   // LANES=4, PIPE=0

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic   in_valid_a  [NCFG];
    logic   in_ready_a  [NCFG];
    logic   in_inv_a    [NCFG];
    state_t in_state_a  [NCFG];
    logic   out_valid_a [NCFG];
    logic   out_ready_a [NCFG];
    state_t out_state_a [NCFG];
    logic   busy_a      [NCFG];

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    // Instance g: LANES = 1 << (g/2), PIPE = g%2.
    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << (g / 2)), .PIPE(g % 2)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_inv    (in_inv_a[g]),
            .in_state  (in_state_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    function automatic state_t cm(input logic [127:0] v);
        state_t s;
        for (int k = 0; k < 16; k++) s[k % 4][k / 4] = v[127 - 8 * k -: 8];
        return s;
    endfunction

    function automatic state_t fill(input byte_t b);
        state_t s;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) s[r][c] = b;
        return s;
    endfunction

    function automatic state_t rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic int cfg_lat(input int i);
        return 16 / (1 << (i / 2)) + (i % 2);
    endfunction

    // Accept one state on instance i, scramble the inputs during RUN, collect result.
    task automatic run_one(input int i, input state_t s, input logic inv,
                           output state_t res, output int lat);
        in_state_a[i] = s;
        in_inv_a[i]   = inv;
        in_valid_a[i] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[i] = 1'b0;
        lat = 0;
        while (lat < 40 && !out_valid_a[i]) begin
            in_inv_a[i]   = ~in_inv_a[i];
            in_state_a[i] = rand_state();
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid_a[i]) begin
            checks++; errors++;
            $display("FAIL timeout cfg %0d: out_valid not seen after %0d cycles", i, lat);
        end
        res = out_state_a[i];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < NCFG; i++) begin
            in_valid_a[i]  = 1'b0;
            in_inv_a[i]    = 1'b0;
            in_state_a[i]  = '0;
            out_ready_a[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < NCFG; i++) begin
            checks++;
            if ({in_ready_a[i], out_valid_a[i], busy_a[i]} !== 3'b100) begin
                errors++;
                $display("FAIL reset_flags cfg %0d: got rdy/vld/busy %b%b%b want 100",
                         i, in_ready_a[i], out_valid_a[i], busy_a[i]);
            end
            checks++;
            if (out_state_a[i] !== state_t'('0)) begin
                errors++;
                $display("FAIL reset_out_state cfg %0d: got %h want 0", i, out_state_a[i]);
            end
        end
    endtask

    task automatic test_fwd_zero();
        state_t res;
        int lat;
        run_one(MAIN, fill(8'h00), 1'b0, res, lat);
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL fwd_zero_latency: got %0d want 4", lat);
        end
        checks++;
        if (res !== fill(8'h63)) begin
            errors++;
            $display("FAIL fwd_zero_data: got %h want %h", res, fill(8'h63));
        end
    endtask

    task automatic test_inv_const();
        state_t res;
        int lat;
        run_one(MAIN, fill(8'h63), 1'b1, res, lat);
        checks++;
        if (res !== fill(8'h00)) begin
            errors++;
            $display("FAIL inv_63: got %h want %h", res, fill(8'h00));
        end
        run_one(MAIN, fill(8'hed), 1'b1, res, lat);
        checks++;
        if (res !== fill(8'h53)) begin
            errors++;
            $display("FAIL inv_ed: got %h want %h", res, fill(8'h53));
        end
    endtask

    task automatic test_lanes_pipe();
        state_t vin;
        state_t vexp;
        state_t res;
        int lat;
        vin  = cm(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        vexp = cm(128'hd42711aee0bf98f1b8b45de51e415230);
        for (int i = 0; i < NCFG; i++) begin
            run_one(i, vin, 1'b0, res, lat);
            checks++;
            if (res !== vexp) begin
                errors++;
                $display("FAIL appb_data cfg %0d: got %h want %h", i, res, vexp);
            end
            checks++;
            if (lat !== cfg_lat(i)) begin
                errors++;
                $display("FAIL appb_latency cfg %0d: got %0d want %0d", i, lat, cfg_lat(i));
            end
        end
    endtask

    task automatic test_backpressure();
        state_t vexp;
        int n;
        vexp = cm(128'hd42711aee0bf98f1b8b45de51e415230);
        out_ready_a[MAIN] = 1'b0;
        in_state_a[MAIN]  = cm(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        in_inv_a[MAIN]    = 1'b0;
        in_valid_a[MAIN]  = 1'b1;
        @(posedge clk); #1;
        n = 0;
        in_state_a[MAIN] = fill(8'h00);
        while (n < 40 && !out_valid_a[MAIN]) begin
            @(posedge clk); #1;
            n++;
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (!(out_valid_a[MAIN] === 1'b1 && out_state_a[MAIN] === vexp && in_ready_a[MAIN] === 1'b0)) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: vld %b rdy %b data %h want vld 1 rdy 0 data %h",
                         k, out_valid_a[MAIN], in_ready_a[MAIN], out_state_a[MAIN], vexp);
            end
        end
        out_ready_a[MAIN] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready_a[MAIN], busy_a[MAIN], out_valid_a[MAIN]} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: got rdy/busy/vld %b%b%b want 100",
                     in_ready_a[MAIN], busy_a[MAIN], out_valid_a[MAIN]);
        end
        @(posedge clk); #1;
        in_valid_a[MAIN] = 1'b0;
        checks++;
        if ({in_ready_a[MAIN], busy_a[MAIN]} !== 2'b01) begin
            errors++;
            $display("FAIL bp_second_accept: got rdy/busy %b%b want 01", in_ready_a[MAIN], busy_a[MAIN]);
        end
        n = 0;
        while (n < 40 && !out_valid_a[MAIN]) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (out_state_a[MAIN] !== fill(8'h63)) begin
            errors++;
            $display("FAIL bp_second_data: got %h want %h", out_state_a[MAIN], fill(8'h63));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        state_t res;
        int lat;
        bit seen;
        in_state_a[MAIN] = cm(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        in_inv_a[MAIN]   = 1'b0;
        in_valid_a[MAIN] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[MAIN] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_a[MAIN] !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_busy_before: got %b want 1", busy_a[MAIN]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({in_ready_a[MAIN], busy_a[MAIN], out_valid_a[MAIN]} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid_flags: got rdy/busy/vld %b%b%b want 100",
                     in_ready_a[MAIN], busy_a[MAIN], out_valid_a[MAIN]);
        end
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid_a[MAIN]) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_no_output: got out_valid pulse, want none");
        end
        run_one(MAIN, fill(8'h53), 1'b0, res, lat);
        checks++;
        if (res !== fill(8'hed)) begin
            errors++;
            $display("FAIL rst_mid_fresh: got %h want %h", res, fill(8'hed));
        end
    endtask

    task automatic test_round_trip();
        state_t s;
        state_t f;
        state_t r;
        logic [127:0] e;
        int lat;
        for (int n = 0; n < 1000; n++) begin
            s = rand_state();
            exp_q.push_back(s);
            run_one(MAIN, s, 1'b0, f, lat);
            run_one(MAIN, f, 1'b1, r, lat);
            e = exp_q.pop_front();
            checks++;
            if (r !== e) begin
                errors++;
                $display("FAIL round_trip %0d: got %h want %h", n, r, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_zero();
        test_inv_const();
        test_lanes_pipe();
        test_backpressure();
        test_reset_mid_run();
        test_round_trip();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
